// File: rtl/seq_mul_pkg.sv
// Shared types and sizing helpers for the sequential shift-and-add multiplier.
package seq_mul_pkg;

  localparam int unsigned StateW = 2;

  typedef enum logic [StateW-1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  // Step counter must hold 0..w-1; keep at least one bit for w == 2.
  function automatic int unsigned cnt_width(int unsigned w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/seq_multiplier_if.sv
// Operand/product valid-ready bundle between a producer/consumer and seq_multiplier.
interface seq_multiplier_if #(
  parameter int unsigned WIDTH = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] p;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, p
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, p
  );
endinterface

// File: rtl/full_adder.sv
// One-bit full adder cell.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);
  assign sum_o  = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));
endmodule

// File: rtl/rca_nbit.sv
// N-bit ripple-carry adder chained from full_adder cells.
module rca_nbit #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         cin_i,
  output logic [N-1:0] sum_o,
  output logic         cout_o
);
  logic [N:0] carry;

  assign carry[0] = cin_i;
  assign cout_o   = carry[N];

  for (genvar i = 0; i < N; i++) begin : g_bit
    full_adder u_fa (
      .a_i   (a_i[i]),
      .b_i   (b_i[i]),
      .cin_i (carry[i]),
      .sum_o (sum_o[i]),
      .cout_o(carry[i+1])
    );
  end
endmodule

// File: rtl/seq_multiplier.sv
// Multi-cycle shift-and-add multiplier, one partial product per clock, valid/ready on both sides.
// Define SEQ_MUL_SIGNED_EN for two's-complement operands and product.
module seq_multiplier
  import seq_mul_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  seq_multiplier_if.slave  bus_io
);
  localparam int unsigned PW   = 2 * WIDTH;
  localparam int unsigned CntW = cnt_width(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] mplr_q, mplr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic [PW-1:0] mcand_load;
  logic [PW-1:0] add_b;
  logic          add_cin;
  logic [PW-1:0] add_sum;
  logic          add_cout_unused;

`ifdef SEQ_MUL_SIGNED_EN
  // The top multiplier bit carries negative weight, so the last step subtracts.
  logic last_step;
  assign last_step  = (cnt_q == CntLast);
  assign mcand_load = {{WIDTH{bus_io.a[WIDTH-1]}}, bus_io.a};
  assign add_b      = last_step ? ~mcand_q : mcand_q;
  assign add_cin    = last_step;
`else
  assign mcand_load = {{WIDTH{1'b0}}, bus_io.a};
  assign add_b      = mcand_q;
  assign add_cin    = 1'b0;
`endif

  rca_nbit #(
    .N(PW)
  ) u_add (
    .a_i   (acc_q),
    .b_i   (add_b),
    .cin_i (add_cin),
    .sum_o (add_sum),
    .cout_o(add_cout_unused)
  );

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    mplr_d  = mplr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus_io.in_valid) begin
          mcand_d = mcand_load;
          mplr_d  = bus_io.b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (mplr_q[0]) begin
          acc_d = add_sum;
        end
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_q >> 1;
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (bus_io.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      mcand_q <= '0;
      acc_q   <= '0;
      mplr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      mplr_q  <= mplr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Held low while reset is asserted so nothing is offered before the first clean cycle.
  assign bus_io.in_ready  = rst_n && (state_q == StIdle);
  assign bus_io.out_valid = (state_q == StDone);
  assign bus_io.p         = acc_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier (WIDTH=4 and WIDTH=8 instances) against an arithmetic model.
module tb_seq_multiplier;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_multiplier_if #(.WIDTH(4)) if4 ();
  seq_multiplier_if #(.WIDTH(8)) if8 ();

  seq_multiplier #(.WIDTH(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus_io(if4)
  );

  seq_multiplier #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus_io(if8)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Product from plain integer arithmetic, truncated to 2*w bits.
  function automatic logic [31:0] ref_mul(int w, int unsigned a, int unsigned b);
    longint sa = longint'(a);
    longint sb = longint'(b);
    longint prod;
`ifdef SEQ_MUL_SIGNED_EN
    if (a >= (32'd1 << (w - 1))) sa = sa - (longint'(1) << w);
    if (b >= (32'd1 << (w - 1))) sb = sb - (longint'(1) << w);
`endif
    prod = sa * sb;
    return 32'(prod & ((longint'(1) << (2 * w)) - 1));
  endfunction

  // Scoreboard for the WIDTH=4 instance, sampled just after each falling edge.
  logic [7:0] exp_q[$];
  int cyc = 0;
  int n_res = 0;
  int prev_hs = 0;
  bit have_prev = 1'b0;
  bit tput_en = 1'b0;

  always begin
    @(negedge clk);
    #1;
    cyc++;
    if (!tput_en) have_prev = 1'b0;
    if (!rst_n) begin
      exp_q.delete();
      have_prev = 1'b0;
    end else begin
      if (if4.out_valid) begin
        check_eq("in_ready_low_in_done", 32'(if4.in_ready), 32'd0);
        if (exp_q.size() == 0) begin
          check_eq("spurious_out_valid", 32'(exp_q.size()), 32'd1);
        end else begin
          check_eq("p4_vs_model", 32'(if4.p), 32'(exp_q[0]));
          if (if4.out_ready) begin
            void'(exp_q.pop_front());
            n_res++;
            if (tput_en && have_prev) check_eq("throughput", 32'(cyc - prev_hs), 32'd6);
            prev_hs   = cyc;
            have_prev = 1'b1;
          end
        end
      end
      if (if4.in_valid && if4.in_ready) begin
        exp_q.push_back(8'(ref_mul(4, 32'(if4.a), 32'(if4.b))));
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after the accepting edge.
  task automatic send4(input logic [3:0] a, input logic [3:0] b);
    int n = 0;
    if4.a = a;
    if4.b = b;
    if4.in_valid = 1'b1;
    while (!if4.in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!if4.in_ready) check_eq("accept_timeout", 32'(if4.in_ready), 32'd1);
    @(negedge clk);
  endtask

  // Waits for out_valid after send4; checks latency and the product.
  task automatic expect_out4(input string tag, input logic [7:0] exp_p);
    int lat = 1;
    while (!if4.out_valid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    check_eq({tag, "_latency"}, 32'(lat), 32'd5);
    check_eq({tag, "_p"}, 32'(if4.p), 32'(exp_p));
  endtask

  task automatic drain4();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check_eq("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    int lat = 1;
    if8.a = a;
    if8.b = b;
    if8.in_valid = 1'b1;
    while (!if8.in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    if8.in_valid = 1'b0;
    while (!if8.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check_eq({tag, "_latency"}, 32'(lat), 32'd9);
    check_eq({tag, "_p"}, 32'(if8.p), ref_mul(8, 32'(a), 32'(b)));
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    bit done;
    if4.in_valid = 1'b0; if4.a = '0; if4.b = '0; if4.out_ready = 1'b1;
    if8.in_valid = 1'b0; if8.a = '0; if8.b = '0; if8.out_ready = 1'b1;

    repeat (3) @(negedge clk);
    check_eq("rst_in_ready", 32'(if4.in_ready), 32'd0);
    check_eq("rst_out_valid", 32'(if4.out_valid), 32'd0);
    check_eq("rst_p", 32'(if4.p), 32'd0);
    check_eq("rst_p8", 32'(if8.p), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_in_ready", 32'(if4.in_ready), 32'd1);

`ifndef SEQ_MUL_SIGNED_EN
    send4(4'd15, 4'd15);
    if4.in_valid = 1'b0;
    expect_out4("mul_15x15", 8'hE1);
    @(negedge clk);
    check_eq("ready_after_hs", 32'(if4.in_ready), 32'd1);
    check_eq("valid_after_hs", 32'(if4.out_valid), 32'd0);
`endif

    // Consumer stall: product must be held.
    if4.out_ready = 1'b0;
    send4(4'd6, 4'd7);
    if4.in_valid = 1'b0;
    expect_out4("stall_6x7", 8'd42);
    for (int k = 0; k < 3; k++) begin
      check_eq("stall_valid", 32'(if4.out_valid), 32'd1);
      check_eq("stall_p", 32'(if4.p), 32'd42);
      check_eq("stall_in_ready", 32'(if4.in_ready), 32'd0);
      @(negedge clk);
    end
    check_eq("stall_valid_4th", 32'(if4.out_valid), 32'd1);
    if4.out_ready = 1'b1;
    @(negedge clk);
    check_eq("stall_released", 32'(if4.out_valid), 32'd0);
    check_eq("stall_ready_back", 32'(if4.in_ready), 32'd1);

    // Reset during the second busy cycle.
    send4(4'd9, 4'd9);
    if4.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("midrst_out_valid", 32'(if4.out_valid), 32'd0);
    check_eq("midrst_p", 32'(if4.p), 32'd0);
    check_eq("midrst_in_ready", 32'(if4.in_ready), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("midrst_idle", 32'(if4.in_ready), 32'd1);
    send4(4'd3, 4'd5);
    if4.in_valid = 1'b0;
    expect_out4("after_rst_3x5", 8'd15);
    @(negedge clk);

    // Exhaustive, back to back with in_valid held high.
    tput_en = 1'b1;
    base = n_res;
    for (int i = 0; i < 256; i++) begin
      send4(4'(i >> 4), 4'(i & 15));
    end
    if4.in_valid = 1'b0;
    drain4();
    tput_en = 1'b0;
    check_eq("exhaustive_count", 32'(n_res - base), 32'd256);

    // Random operands with random gaps and consumer backpressure.
    base = n_res;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          send4(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
          if ($urandom_range(0, 1) == 1) begin
            if4.in_valid = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
          end
        end
        if4.in_valid = 1'b0;
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(negedge clk);
          if4.out_ready = ($urandom_range(0, 1) == 1);
        end
      end
    join
    if4.out_ready = 1'b1;
    drain4();
    check_eq("random_count", 32'(n_res - base), 32'd40);

    run8("w8_255x255", 8'd255, 8'd255);
    run8("w8_0x200", 8'd0, 8'd200);
    run8("w8_rand", 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));

`ifdef SEQ_MUL_SIGNED_EN
    send4(4'h8, 4'h7);
    if4.in_valid = 1'b0;
    expect_out4("s_m8x7", 8'hC8);
    @(negedge clk);
    send4(4'h8, 4'h8);
    if4.in_valid = 1'b0;
    expect_out4("s_m8xm8", 8'h40);
    @(negedge clk);
    send4(4'h7, 4'hF);
    if4.in_valid = 1'b0;
    expect_out4("s_7xm1", 8'hF9);
    @(negedge clk);
`endif

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
